// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter applying one set/clear operation per cycle to a shared flag bank.
// Optional error counter output err_cnt is enabled by defining SR_FLAG_ARB_STATS_EN.
module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAG  = 8,
  parameter int FIDX_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_s,
  input  logic [NREQ-1:0]          req_r,
  input  logic [NREQ*FIDX_W-1:0]   req_idx,
  output logic [NREQ-1:0]          gnt,
  output logic [NFLAG-1:0]         q,
  output logic [NFLAG-1:0]         qbar,
  output logic                     err,
  output logic [NREQ-1:0]          err_id
`ifdef SR_FLAG_ARB_STATS_EN
  ,
  output logic [15:0]              err_cnt
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   gnt_r;
  logic [NFLAG-1:0]  q_r;
  logic [NFLAG-1:0]  qbar_r;
  logic              err_r;
  logic [NREQ-1:0]   err_id_r;
  logic [PTR_W-1:0]  ptr_r;

  logic [NREQ-1:0]   pend_s;
  logic              sel_valid_s;
  logic [PTR_W-1:0]  sel_id_s;
  logic [PTR_W-1:0]  cand_s;
  logic              sel_set_s;
  logic              sel_clr_s;
  logic [FIDX_W-1:0] sel_idx_s;
  logic              illegal_s;
  logic              write_s;
  logic [NFLAG-1:0]  q_next_s;
  logic [PTR_W-1:0]  ptr_next_s;
  logic [NREQ-1:0]   grant_vec_s;

  function automatic logic [NREQ-1:0] one_hot(input logic [PTR_W-1:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(id) == i) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Round-robin pick: a requester granted last cycle is masked for one cycle.
  always_comb begin
    pend_s      = (req_s | req_r) & ~gnt_r;
    sel_valid_s = 1'b0;
    sel_id_s    = '0;
    cand_s      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = PTR_W'((int'(ptr_r) + off) % NREQ);
      if (!sel_valid_s && pend_s[cand_s]) begin
        sel_valid_s = 1'b1;
        sel_id_s    = cand_s;
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Decode the winning operation into flag update, error and pointer advance.
  always_comb begin
    sel_set_s   = req_s[sel_id_s];
    sel_clr_s   = req_r[sel_id_s];
    sel_idx_s   = req_idx[int'(sel_id_s)*FIDX_W +: FIDX_W];
    illegal_s   = sel_valid_s & sel_set_s & sel_clr_s;
    write_s     = sel_valid_s & (sel_set_s ^ sel_clr_s) & (int'(sel_idx_s) < NFLAG);
    grant_vec_s = sel_valid_s ? one_hot(sel_id_s) : {NREQ{1'b0}};
    q_next_s    = q_r;
    for (int f = 0; f < NFLAG; f++) begin
      if (write_s && (int'(sel_idx_s) == f)) begin
        q_next_s[f] = sel_set_s;
      end else begin
        q_next_s[f] = q_r[f];
      end
    end
    if (!sel_valid_s) begin
      ptr_next_s = ptr_r;
    end else if (int'(sel_id_s) == NREQ - 1) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = sel_id_s + PTR_W'(1);
    end
  end

  // Arbitration state and flag bank; qbar is registered alongside q so it never diverges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r    <= '0;
      q_r      <= '0;
      qbar_r   <= '1;
      err_r    <= 1'b0;
      err_id_r <= '0;
      ptr_r    <= '0;
    end else begin
      gnt_r  <= grant_vec_s;
      q_r    <= q_next_s;
      qbar_r <= ~q_next_s;
      ptr_r  <= ptr_next_s;
      err_r  <= illegal_s;
      if (illegal_s) begin
        err_id_r <= grant_vec_s;
      end else begin
        err_id_r <= err_id_r;
      end
    end
  end

`ifdef SR_FLAG_ARB_STATS_EN
  logic [15:0] err_cnt_r;

  // Saturating count of consumed illegal requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= 16'h0000;
    end else if (illegal_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  assign gnt    = gnt_r;
  assign q      = q_r;
  assign qbar   = qbar_r;
  assign err    = err_r;
  assign err_id = err_id_r;

endmodule
